// File: rtl/btn_pkg.sv
// Shared types and default constants for the push-button pulse generator.
package btn_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_t;

  localparam int unsigned DEF_STABLE_CYCLES = 4;
  localparam int unsigned DEF_REPEAT_DELAY  = 64;
  localparam int unsigned DEF_REPEAT_PERIOD = 16;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_sync2.sv
// Two-flop synchronizer bringing the raw button into the CLK domain.
module btn_sync2 (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic s1_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_q <= 1'b0;
      q    <= 1'b0;
    end else begin
      s1_q <= d;
      q    <= s1_q;
    end
  end

endmodule

// File: rtl/button_pulse_gen.sv
// Debounces a push-button into a registered LEVEL and a one-cycle PULSE per press.
// Optional auto-repeat while held is built when AUTO_REPEAT_EN is defined.
module button_pulse_gen
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN_IN,
  output logic PULSE,
  output logic LEVEL
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  if (STABLE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("button_pulse_gen: STABLE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_d, level_d;
  logic             s2;
  logic             rep_fire_c;

  btn_sync2 u_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (BTN_IN),
    .q     (s2)
  );

`ifdef AUTO_REPEAT_EN
  localparam int unsigned REP_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;
  logic             press_accept_c, held_stay_c;

  assign press_accept_c = (state_q == PRESS_WAIT) && s2 && (cnt_q == CNT_W'(STABLE_CYCLES));
  assign held_stay_c    = (state_q == HELD) && s2;
  assign rep_fire_c     = held_stay_c &&
                          (rep_cnt_q == (rep_first_q ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_PERIOD)));

  // rep_cnt counts HELD cycles, the press-pulse cycle being 1; cleared whenever HELD is left.
  always_comb begin
    rep_cnt_d   = '0;
    rep_first_d = 1'b1;
    if (press_accept_c) begin
      rep_cnt_d = REP_W'(1);
    end else if (held_stay_c) begin
      rep_first_d = rep_first_q;
      if (rep_fire_c) begin
        rep_cnt_d   = REP_W'(1);
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_fire_c = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    level_d = LEVEL;
    case (state_q)
      IDLE: begin
        if (s2) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES)) begin
          state_d = HELD;
          pulse_d = 1'b1;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s2) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          pulse_d = rep_fire_c;
        end
      end
      RELEASE_WAIT: begin
        // A return to 1 is release bounce: back to HELD without a new pulse.
        if (s2) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES)) begin
          state_d = IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      PULSE   <= 1'b0;
      LEVEL   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      PULSE   <= pulse_d;
      LEVEL   <= level_d;
    end
  end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Self-checking bench for button_pulse_gen: directed scenarios then random button activity.
module tb_button_pulse_gen;

  localparam int SC = 4;
`ifdef AUTO_REPEAT_EN
  localparam int RD     = 8;
  localparam int RP     = 4;
  localparam bit REP_EN = 1'b1;
`else
  localparam int RD     = 64;
  localparam int RP     = 16;
  localparam bit REP_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET;
  logic BTN_IN;
  logic PULSE;
  logic LEVEL;

  always #5 CLK = ~CLK;

  button_pulse_gen #(
    .STABLE_CYCLES (SC),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .BTN_IN (BTN_IN),
    .PULSE  (PULSE),
    .LEVEL  (LEVEL)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_no   = 0;
  int pulses_seen = 0;
  int first_pulse_cyc = 0;

  // Reference: two-sample delay line, then a run-length debouncer on the delayed samples.
  int m_sy1 = 0, m_sy2 = 0, m_level = 0, m_run = 0, m_pulse = 0, m_hold = 0;

  task automatic model_step(input logic r, input logic b);
    int s2;
    if (r) begin
      m_sy1 = 0; m_sy2 = 0; m_level = 0; m_run = 0; m_pulse = 0; m_hold = 0;
      return;
    end
    s2    = m_sy2;
    m_sy2 = m_sy1;
    m_sy1 = b ? 1 : 0;
    m_pulse = 0;
    if (s2 != m_level) begin
      m_run++;
      if (m_run == SC + 1) begin
        m_level = s2;
        m_run   = 0;
        if (m_level == 1) begin
          m_pulse = 1;
          m_hold  = 0;
        end
      end
    end else if (m_run != 0) begin
      m_run  = 0;
      m_hold = -1;
    end else if (REP_EN && m_level == 1) begin
      m_hold++;
      if (m_hold == RD || (m_hold > RD && (m_hold - RD) % RP == 0)) m_pulse = 1;
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc_no);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc_no);
    end
  endtask

  task automatic cyc(input logic r, input logic b);
    RESET  = r;
    BTN_IN = b;
    @(posedge CLK);
    model_step(r, b);
    cyc_no++;
    @(negedge CLK);
    check_bit("pulse", PULSE, m_pulse != 0);
    check_bit("level", LEVEL, m_level != 0);
    if (PULSE === 1'b1) begin
      if (pulses_seen == 0) first_pulse_cyc = cyc_no;
      pulses_seen++;
    end
  endtask

  task automatic arm();
    pulses_seen     = 0;
    first_pulse_cyc = 0;
  endtask

  initial begin
    int t0;
    RESET  = 1'b1;
    BTN_IN = 1'b0;
    repeat (3) cyc(1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b0);

    // Clean press held 20 cycles
    arm(); t0 = cyc_no;
    repeat (20) cyc(1'b0, 1'b1);
    check_int("press_latency", first_pulse_cyc - t0, SC + 3);
    check_int("press_pulses", pulses_seen, REP_EN ? 3 : 1);
    repeat (12) cyc(1'b0, 1'b0);

    // Glitch shorter than the debounce window
    arm();
    repeat (3) cyc(1'b0, 1'b1);
    repeat (10) cyc(1'b0, 1'b0);
    check_int("glitch_pulses", pulses_seen, 0);

    // Bouncy release
    repeat (12) cyc(1'b0, 1'b1);
    arm();
    repeat (2) cyc(1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b1);
    repeat (10) cyc(1'b0, 1'b0);
    check_int("bounce_pulses", pulses_seen, 0);
    check_bit("bounce_level_low", LEVEL, 1'b0);
    repeat (4) cyc(1'b0, 1'b0);

    // Reset in the middle of the press debounce
    repeat (3) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    arm(); t0 = cyc_no;
    repeat (10) cyc(1'b0, 1'b1);
    check_int("rst_press_latency", first_pulse_cyc - t0, SC + 3);
    repeat (12) cyc(1'b0, 1'b0);

    // Reset while held, button still down
    repeat (10) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    check_bit("rst_held_level", LEVEL, 1'b0);
    arm(); t0 = cyc_no;
    repeat (10) cyc(1'b0, 1'b1);
    check_int("rst_held_latency", first_pulse_cyc - t0, SC + 3);
    repeat (12) cyc(1'b0, 1'b0);

    // Long hold: auto-repeat when built in, otherwise a single pulse
    arm();
    repeat (30) cyc(1'b0, 1'b1);
    check_int("hold_pulses", pulses_seen, REP_EN ? 5 : 1);
    repeat (12) cyc(1'b0, 1'b0);

    // Random button activity with occasional reset
    for (int i = 0; i < 60; i++) begin
      int  len;
      logic val;
      len = int'($urandom_range(1, 12));
      val = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        cyc(($urandom_range(0, 49) == 0), val);
      end
    end
    repeat (12) cyc(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
